prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader; the writer side of the main-memory instruction fetch path.
//  Receives a length-prefixed, big-endian byte stream and assembles 16-bit instruction words.
//  Writes each word into synchronous main memory.
//  Holds the microprogrammed CPU (cpu_hold) until the image is fully loaded.
// PARAMETERS
//  ADDR_W     8    main-memory address width
//  BASE_ADDR  0    memory address of instruction word 0
//  MAX_WORDS  256  largest accepted program length (words); must be <= 2**ADDR_W
// PORTS
//  clock       in   1       system clock; all state changes on the rising edge
//  reset       in   1       synchronous, active-high
//  start       in   1       begin a load; honoured in IDLE, DONE and ERR only
//  byte_in     in   8       stream byte
//  byte_valid  in   1       byte_in is valid
//  byte_ready  out  1       loader can accept a byte; transfer = byte_valid & byte_ready at an edge
//  mem_we      out  1       one-cycle memory write strobe
//  mem_addr    out  ADDR_W  write address
//  mem_wdata   out  16      write data
//  cpu_hold    out  1       1 = CPU held (clock-enable low)
//  done        out  1       load completed successfully (level)
//  error       out  1       load aborted (level)
//  word_cnt    out  16      words written so far in the current load
// BEHAVIOUR
//  Reset state (next edge with reset=1): state=IDLE, cpu_hold=1, all other outputs 0.
//    Reset mid-load abandons the load; writes already issued are not undone.
//  Stream format: LEN_HI, LEN_LO, then LEN words as {HI,LO}, then the checksum (see CONFIGURATION).
//  FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK_HI, CHK_LO, DONE, ERR.
//  IDLE -start-> LEN_HI.
//    Entering LEN_HI from IDLE/DONE/ERR: cpu_hold=1, done=0, error=0, word_cnt=0.
//  byte_ready=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO.
//  Each state advances only on an accepted byte. A byte_valid stall of any length is legal.
//  LEN_LO accepted:
//    len==0 -> DONE, or CHK_HI if CHECKSUM_EN; no writes.
//    len>MAX_WORDS -> ERR.
//    otherwise -> DATA_HI.
//  DATA_HI latches the high byte; DATA_LO latches the low byte -> WRITE.
//  WRITE (one cycle):
//    mem_we=1, mem_wdata={hi,lo}, mem_addr=(BASE_ADDR+word_cnt) mod 2**ADDR_W (wraps, no error).
//    byte_ready=0.
//    word_cnt increments at the end of WRITE.
//    Next state: DATA_HI if word_cnt+1<len; else CHK_HI (CHECKSUM_EN) or DONE.
//  mem_we is 0 in every state except WRITE. mem_addr/mem_wdata hold their last value otherwise.
//  Throughput: 3 cycles per word minimum; with byte_valid held high, a word is written every 3 edges.
//  DONE: done=1, cpu_hold=0; sticky until start or reset.
//  ERR: error=1, cpu_hold=1; sticky until start or reset.
//  start in any loading state is ignored.
//    If start and byte_valid coincide in DONE/ERR, the byte is not accepted (byte_ready=0 there).
//  Bytes presented in IDLE/WRITE/DONE/ERR are not consumed.
// CONFIGURATION
//  CHECKSUM_EN defined:
//    16-bit running sum (mod 2**16) of every written word, cleared on start.
//    After the last word (or len==0): CHK_HI, CHK_LO accept the expected sum.
//    Match -> DONE; mismatch -> ERR, with cpu_hold kept at 1.
//  CHECKSUM_EN undefined:
//    No checksum bytes; CHK_HI/CHK_LO are unreachable.
//    The state after the last WRITE is DONE.
// TESTING
//  1. reset=1 for 2 cycles -> cpu_hold=1, done=0, error=0, byte_ready=0, mem_we=0, word_cnt=0.
//  2. start; bytes 00 02 12 34 AB CD, valid held high; with CHECKSUM_EN also BE 01 ->
//     writes (0x00,0x1234) then (0x01,0xABCD), each mem_we exactly 1 cycle; then done=1, cpu_hold=0.
//  3. Same stream with byte_valid dropped for 5 cycles between 12 and 34 ->
//     identical writes; no byte is lost or duplicated.
//  4. Length bytes 01 01 (257 > MAX_WORDS) -> ERR: error=1, cpu_hold=1, no mem_we.
//     Then start -> error=0 and a new load proceeds.
//  5. BASE_ADDR=0xFE, ADDR_W=8, 3 words -> addresses 0xFE, 0xFF, 0x00.
//  6. CHECKSUM_EN: test 2 with checksum BE 02 -> both words written, then error=1 and cpu_hold=1.
//     Also: reset asserted during DATA_LO -> IDLE next edge; no further writes.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words from a length-prefixed
// stream, writes them to main memory and releases cpu_hold when done. Optional macro: CHECKSUM_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for start after reset, CPU held
// S_LEN_HI  | accept length high byte
// S_LEN_LO  | accept length low byte, range-check length
// S_DATA_HI | accept instruction word high byte
// S_DATA_LO | accept instruction word low byte
// S_WRITE   | one-cycle memory write, advance word counter
// S_CHK_HI  | accept checksum high byte (CHECKSUM_EN only)
// S_CHK_LO  | accept checksum low byte and compare (CHECKSUM_EN only)
// S_DONE    | image loaded, CPU released
// S_ERR     | load aborted, CPU held
module prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          MAX_WORDS = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHK_HI,
        S_CHK_LO,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    logic [15:0] len;
    logic [7:0]  hi_byte;
    logic        accept;
    logic        last_word;
    logic [15:0] len_next;

`ifdef CHECKSUM_EN
    logic [15:0] sum;
    logic [7:0]  chk_hi;
`endif

    assign accept    = byte_valid & byte_ready;
    assign len_next  = {len[15:8], byte_in};
    // word_cnt has not yet been incremented while in S_WRITE
    assign last_word = ({1'b0, word_cnt} + 17'd1) >= {1'b0, len};

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_cnt   <= '0;
            len        <= '0;
            hi_byte    <= '0;
`ifdef CHECKSUM_EN
            sum        <= '0;
            chk_hi     <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN_HI;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_cnt   <= '0;
`ifdef CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= byte_in;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= byte_in;
                        if (len_next == 16'd0) begin
`ifdef CHECKSUM_EN
                            state      <= S_CHK_HI;
`else
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
`endif
                        end else if ({1'b0, len_next} > MAX_LEN) begin
                            state      <= S_ERR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        hi_byte <= byte_in;
                        state   <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        state      <= S_WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_wdata  <= {hi_byte, byte_in};
                        mem_addr   <= BASE + ADDR_W'(word_cnt);
`ifdef CHECKSUM_EN
                        sum        <= sum + {hi_byte, byte_in};
`endif
                    end
                end
                S_WRITE: begin
                    word_cnt <= word_cnt + 16'd1;
                    if (!last_word) begin
                        state      <= S_DATA_HI;
                        byte_ready <= 1'b1;
                    end else begin
`ifdef CHECKSUM_EN
                        state      <= S_CHK_HI;
                        byte_ready <= 1'b1;
`else
                        state      <= S_DONE;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
`endif
                    end
                end
`ifdef CHECKSUM_EN
                S_CHK_HI: begin
                    if (accept) begin
                        chk_hi <= byte_in;
                        state  <= S_CHK_LO;
                    end
                end
                S_CHK_LO: begin
                    if (accept) begin
                        byte_ready <= 1'b0;
                        if ({chk_hi, byte_in} == sum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: two instances (BASE_ADDR 0 and 0xFE) share one
// stream; results are compared against a stream-level model of the load.
module tb_prog_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;

    logic        br0, we0, hold0, done0, err0;
    logic [7:0]  addr0;
    logic [15:0] wd0, wc0;
    logic        br1, we1, hold1, done1, err1;
    logic [7:0]  addr1;
    logic [15:0] wd1, wc1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  w_addr0[$];
    logic [15:0] w_data0[$];
    int          w_cyc[$];
    logic [7:0]  w_addr1[$];
    logic [15:0] w_data1[$];

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(256)) dut0 (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(br0), .mem_we(we0), .mem_addr(addr0),
        .mem_wdata(wd0), .cpu_hold(hold0), .done(done0), .error(err0), .word_cnt(wc0)
    );

    prog_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE), .MAX_WORDS(256)) dut1 (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(br1), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wd1), .cpu_hold(hold1), .done(done1), .error(err1), .word_cnt(wc1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (we0) begin
            w_addr0.push_back(addr0);
            w_data0.push_back(wd0);
            w_cyc.push_back(cyc);
        end
        if (we1) begin
            w_addr1.push_back(addr1);
            w_data1.push_back(wd1);
        end
    end

    function automatic bq_t make_stream(input wq_t words, input bit bad_chk);
        bq_t s;
        logic [15:0] sum;
        logic [15:0] n;
        sum = 16'h0000;
        n = 16'(words.size());
        s.push_back(n[15:8]);
        s.push_back(n[7:0]);
        foreach (words[i]) begin
            s.push_back(words[i][15:8]);
            s.push_back(words[i][7:0]);
            sum = sum + words[i];
        end
        if (bad_chk) sum = sum + 16'd1;
`ifdef CHECKSUM_EN
        s.push_back(sum[15:8]);
        s.push_back(sum[7:0]);
`endif
        return s;
    endfunction

    task automatic send_bytes(input bq_t s, input int n, input int stall_max,
                              input int stall_idx, input int stall_len, output bit ok);
        bit acc;
        int waited;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            waited = 0;
            if (i == stall_idx) begin
                byte_valid = 1'b0;
                repeat (stall_len) @(negedge clock);
            end
            while (!acc) begin
                if (stall_max > 0 && $urandom_range(0, 3) == 0) begin
                    byte_valid = 1'b0;
                    repeat ($urandom_range(1, stall_max)) @(negedge clock);
                end
                byte_valid = 1'b1;
                byte_in = s[i];
                acc = br0;
                @(negedge clock);
                waited++;
                if (!acc && waited > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout byte %0d: byte_ready stayed %0b, required 1", i, br0);
                    byte_valid = 1'b0;
                    ok = 1'b0;
                    return;
                end
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input string name);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (br0 !== 1'b1 || err0 !== 1'b0 || done0 !== 1'b0 || hold0 !== 1'b1 || wc0 !== 16'd0) begin
            errors++;
            $display("FAIL %s start_state: ready/err/done/hold/cnt=%0b/%0b/%0b/%0b/%0d, required 1/0/0/1/0",
                     name, br0, err0, done0, hold0, wc0);
        end
    endtask

    // Expected outcome derived directly from the stream format
    task automatic run_load(input string name, input bq_t s, input int stall_max,
                            input int stall_idx, input int stall_len);
        int          len, nbytes, exp_n, b0, b1;
        bit          exp_err, ok;
        wq_t         exp_words;
        logic [7:0]  exp_a1;
`ifdef CHECKSUM_EN
        logic [15:0] exp_sum;
        logic [15:0] chk;
`endif
        len = {s[0], s[1]};
        exp_err = 1'b0;
        if (len > 256) begin
            exp_err = 1'b1;
            nbytes = 2;
        end else begin
            for (int i = 0; i < len; i++) exp_words.push_back({s[2 + 2*i], s[3 + 2*i]});
            nbytes = 2 + 2*len;
`ifdef CHECKSUM_EN
            exp_sum = 16'h0000;
            foreach (exp_words[i]) exp_sum = exp_sum + exp_words[i];
            chk = {s[nbytes], s[nbytes + 1]};
            exp_err = (chk != exp_sum);
            nbytes = nbytes + 2;
`endif
        end
        exp_n = exp_words.size();
        b0 = w_data0.size();
        b1 = w_data1.size();

        pulse_start(name);
        send_bytes(s, nbytes, stall_max, stall_idx, stall_len, ok);
        for (int k = 0; k < 10 && !(done0 || err0); k++) @(negedge clock);
        repeat (2) @(negedge clock);

        checks++;
        if (done0 !== !exp_err || err0 !== exp_err) begin
            errors++;
            $display("FAIL %s status: done=%0b error=%0b, required done=%0b error=%0b",
                     name, done0, err0, !exp_err, exp_err);
        end
        checks++;
        if (hold0 !== exp_err) begin
            errors++;
            $display("FAIL %s cpu_hold: got %0b, required %0b", name, hold0, exp_err);
        end
        checks++;
        if (br0 !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_after: got %0b, required 0", name, br0);
        end
        checks++;
        if (wc0 !== 16'(exp_n)) begin
            errors++;
            $display("FAIL %s word_cnt: got %0d, required %0d", name, wc0, exp_n);
        end
        checks++;
        if (done1 !== done0 || err1 !== err0 || hold1 !== hold0) begin
            errors++;
            $display("FAIL %s dut1_status: done/err/hold=%0b/%0b/%0b, required %0b/%0b/%0b",
                     name, done1, err1, hold1, done0, err0, hold0);
        end
        checks++;
        if (w_data0.size() - b0 != exp_n || w_data1.size() - b1 != exp_n) begin
            errors++;
            $display("FAIL %s write_count: got %0d/%0d, required %0d",
                     name, w_data0.size() - b0, w_data1.size() - b1, exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                exp_a1 = 8'((254 + i) % 256);
                checks++;
                if (w_data0[b0+i] !== exp_words[i] || w_addr0[b0+i] !== 8'(i % 256) ||
                    w_data1[b1+i] !== exp_words[i] || w_addr1[b1+i] !== exp_a1) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got a0=%02h d0=%04h a1=%02h d1=%04h, required a0=%02h a1=%02h d=%04h",
                             name, i, w_addr0[b0+i], w_data0[b0+i], w_addr1[b1+i], w_data1[b1+i],
                             8'(i % 256), exp_a1, exp_words[i]);
                end
                if (stall_max == 0 && stall_idx < 0 && i > 0) begin
                    checks++;
                    if (w_cyc[b0+i] - w_cyc[b0+i-1] != 3) begin
                        errors++;
                        $display("FAIL %s spacing[%0d]: got %0d cycles, required 3",
                                 name, i, w_cyc[b0+i] - w_cyc[b0+i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        checks++;
        if (hold0 !== 1'b1 || done0 !== 1'b0 || err0 !== 1'b0 || br0 !== 1'b0 ||
            we0 !== 1'b0 || wc0 !== 16'd0 || addr0 !== 8'd0 || wd0 !== 16'd0) begin
            errors++;
            $display("FAIL reset: hold/done/err/ready/we/cnt=%0b/%0b/%0b/%0b/%0b/%0d, required 1/0/0/0/0/0",
                     hold0, done0, err0, br0, we0, wc0);
        end
        @(negedge clock);
        checks++;
        if (br0 !== 1'b0 || hold0 !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: ready=%0b hold=%0b, required 0 1", br0, hold0);
        end
    endtask

    task automatic test_basic();
        wq_t w;
        w = '{16'h1234, 16'hABCD};
        run_load("basic", make_stream(w, 1'b0), 0, -1, 0);
    endtask

    task automatic test_stall();
        wq_t w;
        w = '{16'h1234, 16'hABCD};
        run_load("stall", make_stream(w, 1'b0), 0, 3, 5);
    endtask

    task automatic test_len_error();
        bq_t s;
        wq_t w;
        s = '{8'h01, 8'h01};
        run_load("len_257", s, 0, -1, 0);
        w = '{16'hBEEF};
        run_load("after_error", make_stream(w, 1'b0), 0, -1, 0);
    endtask

    task automatic test_wrap();
        wq_t w;
        w = '{16'h0A0B, 16'hC0DE, 16'hF00D};
        run_load("wrap", make_stream(w, 1'b0), 0, -1, 0);
    endtask

    task automatic test_bad_checksum();
        wq_t w;
        w = '{16'h1234, 16'hABCD};
        run_load("bad_checksum", make_stream(w, 1'b1), 0, -1, 0);
    endtask

    task automatic test_zero_len();
        wq_t w;
        run_load("zero_len", make_stream(w, 1'b0), 0, -1, 0);
    endtask

    task automatic test_max_len();
        wq_t w;
        for (int i = 0; i < 256; i++) w.push_back(16'($urandom));
        run_load("max_len", make_stream(w, 1'b0), 0, -1, 0);
    endtask

    task automatic test_reset_mid_load();
        wq_t w;
        bq_t s;
        bit ok;
        int b0;
        w = '{16'h1234, 16'hABCD};
        s = make_stream(w, 1'b0);
        b0 = w_data0.size();
        pulse_start("mid_reset");
        send_bytes(s, 5, 0, -1, 0, ok);
        checks++;
        if (br0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset in_data_lo: ready=%0b, required 1", br0);
        end
        reset = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'hCD;
        @(negedge clock);
        reset = 1'b0;
        byte_valid = 1'b0;
        checks++;
        if (br0 !== 1'b0 || hold0 !== 1'b1 || we0 !== 1'b0 || wc0 !== 16'd0 ||
            done0 !== 1'b0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset state: ready/hold/we/cnt/done/err=%0b/%0b/%0b/%0d/%0b/%0b, required 0/1/0/0/0/0",
                     br0, hold0, we0, wc0, done0, err0);
        end
        repeat (6) @(negedge clock);
        checks++;
        if (w_data0.size() - b0 != 1 || w_data0[b0] !== 16'h1234) begin
            errors++;
            $display("FAIL mid_reset writes: got %0d writes, required 1 (0x1234)", w_data0.size() - b0);
        end
    endtask

    task automatic test_random();
        wq_t w;
        int n;
        for (int t = 0; t < 8; t++) begin
            w.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            run_load($sformatf("random%0d", t), make_stream(w, $urandom_range(0, 3) == 0),
                     $urandom_range(0, 3), -1, 0);
        end
    endtask

    task automatic test_back_to_back();
        wq_t w;
        w = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
        run_load("b2b_a", make_stream(w, 1'b0), 0, -1, 0);
        w = '{16'h5555};
        run_load("b2b_b", make_stream(w, 1'b0), 0, -1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len_error();
        test_wrap();
        test_bad_checksum();
        test_zero_len();
        test_max_len();
        test_reset_mid_load();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
